// File: rtl/led_breather_pkg.sv
// Shared types and default parameters for the LED breather.
package led_breather_pkg;

  typedef enum logic [1:0] {
    StRise   = 2'd0,
    StHoldHi = 2'd1,
    StFall   = 2'd2,
    StHoldLo = 2'd3
  } phase_e;

  localparam int unsigned CntWDef      = 31;
  localparam int unsigned PwmWDef      = 8;
  localparam int unsigned StepBitDef   = 14;
  localparam int unsigned HoldStepsDef = 64;

endpackage

// File: rtl/led_breather_if.sv
// Counter-in / LED-out bundle for led_breather; slave is the breather, master the driver.
interface led_breather_if
  import led_breather_pkg::*;
#(
  parameter int unsigned CNT_W = CntWDef,
  parameter int unsigned PWM_W = PwmWDef
) ();

  logic [CNT_W-1:0] count;
  logic             en;
  logic             LED;
  logic [PWM_W-1:0] level;
  logic [1:0]       phase;
  logic             step_o;

  modport master (output count, en, input LED, level, phase, step_o);
  modport slave  (input count, en, output LED, level, phase, step_o);

endinterface

// File: rtl/led_breather_rise_edge_det.sv
// Registered rising-edge detector; output is combinational from the live input.
module rise_edge_det (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_rise
);

  logic r_prev;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= i_d;
    end
  end

  assign o_rise = i_d & ~r_prev;

endmodule

// File: rtl/led_breather.sv
// Breathing-LED controller: ramp/hold FSM plus PWM, all timed from the external counter bus.
module led_breather
  import led_breather_pkg::*;
#(
  parameter int unsigned CNT_W      = CntWDef,
  parameter int unsigned PWM_W      = PwmWDef,
  parameter int unsigned STEP_BIT   = StepBitDef,
  parameter int unsigned HOLD_STEPS = HoldStepsDef
) (
  input  logic           CLK,
  input  logic           RST,
  led_breather_if.slave  bus
);

  localparam int unsigned      HoldW    = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
  localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_STEPS - 1);
  localparam logic [HoldW-1:0] HoldOne  = HoldW'(1);
  localparam logic [PWM_W-1:0] LevelMax = '1;
  localparam logic [PWM_W-1:0] LevelOne = PWM_W'(1);

  phase_e           r_phase;
  logic [PWM_W-1:0] r_level;
  logic [PWM_W-1:0] r_duty;
  logic [HoldW-1:0] r_hold_cnt;
  logic             r_led;
  logic             r_step;

  logic             w_step;
  logic             w_period_start;
  logic [PWM_W-1:0] w_duty_eff;

  rise_edge_det u_step_det (
    .i_clk  (CLK),
    .i_rst  (RST),
    .i_d    (bus.count[STEP_BIT]),
    .o_rise (w_step)
  );

  assign w_period_start = (bus.count[PWM_W-1:0] == '0);
  // The shadow loads on period start, so the comparator must see the new value that cycle too.
  assign w_duty_eff     = w_period_start ? r_level : r_duty;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_phase    <= StRise;
      r_level    <= '0;
      r_duty     <= '0;
      r_hold_cnt <= '0;
      r_led      <= 1'b0;
      r_step     <= 1'b0;
    end else begin
      r_step <= w_step;
      r_led  <= bus.en & (bus.count[PWM_W-1:0] < w_duty_eff);
      if (w_period_start) begin
        r_duty <= r_level;
      end
      if (w_step && bus.en) begin
        unique case (r_phase)
          StRise: begin
            if (r_level == LevelMax) begin
              r_phase    <= StHoldHi;
              r_hold_cnt <= '0;
            end else begin
              r_level <= r_level + LevelOne;
            end
          end
          StHoldHi: begin
            if (r_hold_cnt == HoldLast) begin
              r_phase    <= StFall;
              r_hold_cnt <= '0;
            end else begin
              r_hold_cnt <= r_hold_cnt + HoldOne;
            end
          end
          StFall: begin
            if (r_level == '0) begin
              r_phase    <= StHoldLo;
              r_hold_cnt <= '0;
            end else begin
              r_level <= r_level - LevelOne;
            end
          end
          StHoldLo: begin
            if (r_hold_cnt == HoldLast) begin
              r_phase    <= StRise;
              r_hold_cnt <= '0;
            end else begin
              r_hold_cnt <= r_hold_cnt + HoldOne;
            end
          end
        endcase
      end
    end
  end

  assign bus.LED    = r_led;
  assign bus.level  = r_level;
  assign bus.phase  = r_phase;
  assign bus.step_o = r_step;

endmodule

// File: tb/tb_led_breather.sv
// Scoreboard bench for led_breather with PWM_W=4, STEP_BIT=5, HOLD_STEPS=2.
module tb_led_breather;

  typedef struct {
    int lvl;
    int ph;
  } step_exp_t;

  logic      clk;
  logic      rst;
  step_exp_t exp_q[$];
  int        checks     = 0;
  int        failures   = 0;
  int        k          = 0;
  int        steps_seen = 0;

  led_breather_if #(.CNT_W(31), .PWM_W(4)) bus ();

  led_breather #(
    .CNT_W      (31),
    .PWM_W      (4),
    .STEP_BIT   (5),
    .HOLD_STEPS (2)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d, want %0d", name, act, req);
    end
  endtask

  // Hand-derived 36-step breathing cycle: 15 up + sat, 2 hold, 15 down + sat, 2 hold.
  function automatic step_exp_t exp_at(input int kk);
    step_exp_t e;
    int m;
    m = ((kk - 1) % 36) + 1;
    if (m <= 15)      begin e.lvl = m;      e.ph = 0; end
    else if (m <= 17) begin e.lvl = 15;     e.ph = 1; end
    else if (m == 18) begin e.lvl = 15;     e.ph = 2; end
    else if (m <= 33) begin e.lvl = 33 - m; e.ph = 2; end
    else if (m <= 35) begin e.lvl = 0;      e.ph = 3; end
    else              begin e.lvl = 0;      e.ph = 0; end
    return e;
  endfunction

  task automatic push_step();
    if (bus.en) k++;
    exp_q.push_back(exp_at(k));
  endtask

  task automatic drive(input int unsigned c, input bit stp);
    bus.count = 31'(c);
    if (stp) push_step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int unsigned a, input int unsigned b);
    for (int unsigned c = a; c <= b; c++) drive(c, (c % 64) == 32);
  endtask

  task automatic pwm_period(input int unsigned base, input int duty, input string name);
    int hi;
    int bad;
    hi  = 0;
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      drive(base + i, 1'b0);
      if (bus.LED) hi++;
      if (bus.LED != (i < duty)) bad++;
    end
    check({name, "_high"}, hi, duty);
    check({name, "_shape"}, bad, 0);
  endtask

  always @(negedge clk) begin : monitor
    step_exp_t e;
    if (!rst && bus.step_o) begin
      steps_seen++;
      if (exp_q.size() == 0) begin
        check("unexpected_step", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("step_level", int'(bus.level), e.lvl);
        check("step_phase", int'(bus.phase), e.ph);
      end
    end
  end

  initial begin : stim
    int s0;
    int bad;
    rst       = 1'b1;
    bus.en    = 1'b1;
    bus.count = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_led", int'(bus.LED), 0);
    check("reset_level", int'(bus.level), 0);
    check("reset_phase", int'(bus.phase), 0);
    check("reset_step", int'(bus.step_o), 0);
    rst = 1'b0;

    // Ramp with PWM checks at level 5, then a count jump that lands a step mid-period.
    run(0, 319);
    pwm_period(320, 5, "pwm5");
    run(336, 530);
    drive(551, 1'b1);
    check("jump_led_old_duty", int'(bus.LED), 1);
    drive(552, 1'b0);
    check("mid_period_old_duty", int'(bus.LED), 0);
    check("mid_period_level", int'(bus.level), 9);
    run(553, 559);
    pwm_period(560, 9, "pwm9");
    run(576, 2479);

    // Enable low for 200 cycles at level 3.
    bus.en = 1'b0;
    bad    = 0;
    for (int unsigned c = 2480; c < 2680; c++) begin
      drive(c, (c % 64) == 32);
      if (c == 2480) check("en_low_led_next", int'(bus.LED), 0);
      if (bus.LED) bad++;
    end
    check("en_low_led_all", bad, 0);
    check("en_low_level", int'(bus.level), 3);
    bus.en = 1'b1;
    run(2680, 2912);
    check("resume_level", int'(bus.level), 7);
    drive(2913, 1'b0);
    check("led_before_rst", int'(bus.LED), 1);

    // Asynchronous reset between edges.
    #2 rst = 1'b1;
    #1;
    check("async_rst_led", int'(bus.LED), 0);
    check("async_rst_level", int'(bus.level), 0);
    check("async_rst_phase", int'(bus.phase), 0);

    // Count jumps: 10 -> 40 steps once, 40 -> 50 does not.
    repeat (2) @(posedge clk);
    bus.count = 31'd10;
    k         = 0;
    @(negedge clk);
    rst = 1'b0;
    s0  = steps_seen;
    drive(10, 1'b0);
    drive(40, 1'b1);
    repeat (4) drive(50, 1'b0);
    check("jump_steps", steps_seen - s0, 1);
    check("jump_level", int'(bus.level), 1);

    // Reset released with count[5] already high: step on the first edge.
    @(negedge clk);
    rst       = 1'b1;
    bus.count = 31'd33;
    k         = 0;
    @(negedge clk);
    rst = 1'b0;
    s0  = steps_seen;
    drive(33, 1'b1);
    drive(33, 1'b0);
    drive(33, 1'b0);
    check("first_edge_steps", steps_seen - s0, 1);
    check("first_edge_level", int'(bus.level), 1);
    check("queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/led_breather.md
# led_breather

Downstream consumer of the free-running 31-bit board counter. It derives a brightness-step strobe and a PWM compare value from the counter bus. A four-phase state machine ramps LED brightness up, holds, ramps down and holds, producing a glitch-free "breathing" LED on the TinyFPGA BX user LED. It contains no counter of its own for PWM or step timing; all timebase comes from the `count` input.

## Interface
- `CNT_W`, default 31: width of the incoming counter bus.
- `PWM_W`, default 8: PWM resolution; `count[PWM_W-1:0]` is the PWM carrier.
- `STEP_BIT`, default 14: counter bit whose rising edge is one brightness step (every 2^15 cycles = 2.048 ms at 16 MHz).
- `HOLD_STEPS`, default 64: steps spent in each hold phase. Legal range is ≥1.

Ports:
- `CLK` in 1: 16 MHz clock.
- `RST` in 1: reset. One clock; reset is asynchronous and active-high.
- `count` in CNT_W: free-running counter value from the counter stage.
- `en` in 1: run enable.
- `LED` out 1: registered PWM output.
- `level` out PWM_W: current target brightness.
- `phase` out 2: FSM state (RISE=0, HOLD_HI=1, FALL=2, HOLD_LO=3).
- `step_o` out 1: one-cycle step strobe, for debug and verification.

## Operation
- **Step strobe:** `prev` <= `count[STEP_BIT]`. `step` = `count[STEP_BIT] & ~prev`. `step_o` is `step` registered.
- **FSM:** acts only when `step & en`. Otherwise state, `level` and `hold_cnt` are frozen.
  - RISE: if `level`==all-ones, go to HOLD_HI and set `hold_cnt`=0. Otherwise `level`+1.
  - HOLD_HI: if `hold_cnt`==HOLD_STEPS-1, go to FALL and set `hold_cnt`=0. Otherwise `hold_cnt`+1.
  - FALL: if `level`==0, go to HOLD_LO and set `hold_cnt`=0. Otherwise `level`-1.
  - HOLD_LO: same as HOLD_HI, but the exit goes to RISE.
  - `level` never wraps. The saturation checks above take priority over increment/decrement.
- **Duty shadow:** `duty` <= `level` only on cycles where `count[PWM_W-1:0]`==0 (period start). Otherwise `duty` holds. This avoids mid-period glitches.
- **PWM:** `LED` <= `en & (count[PWM_W-1:0] < duty_eff)`.
  - `duty_eff` = `level` on period-start cycles, otherwise `duty`.
  - Duty 0 gives `LED` always 0. Duty all-ones gives `LED` high 2^PWM_W−1 of 2^PWM_W cycles.
- **`en` low:** `LED` is forced to 0 from the next edge. The FSM freezes. The duty shadow keeps updating. On `en` high again, operation resumes from the frozen state with no reset of phase.
- **Count discontinuities:** jumps in `count` are tolerated. Only rising edges of `count[STEP_BIT]` advance the FSM.

## Timing
- **Reset values:** `LED`=0, `level`=0, `phase`=RISE, `step_o`=0, `duty`=0, `hold_cnt`=0, `prev`=0.
- **First edge after reset:** if `count[STEP_BIT]`=1 on the first edge after `RST` deasserts, one step is generated. This is required behaviour.
- **Step latency:**
  - `step` is combinational in the cycle `count[STEP_BIT]` first reads 1.
  - `level` and `phase` update on that edge.
  - `step_o` goes high for exactly one cycle, on the same edge.
- **LED latency:** one cycle from `count`.
- **Mid-operation reset:** `RST` asserted mid-ramp clears everything immediately (asynchronously). `LED` drops without waiting for a PWM period boundary.
- **Full cycle length:** (2·(2^PWM_W) + 2·HOLD_STEPS) steps. The ramps include the saturation step.

## Structure
- Package `led_breather_pkg` holds:
  - the 2-bit state typedef and the four encodings above;
  - the parameter default constants.
- One sub-module, `rise_edge_det` (1-bit registered rising-edge detector, async active-high reset), produces `step`.
- The FSM, saturating level counter, hold counter, duty shadow and PWM comparator live in the top.

## Test plan
All scenarios use PWM_W=4, STEP_BIT=5, HOLD_STEPS=2, with `count` driven from a bench counter starting at 0 and `en`=1.

1. **Reset:** hold `RST` for 3 cycles → all outputs 0 and `phase`=0. The first `step_o` occurs at `count`=32, where `level` becomes 1.
2. **Ramp:** run until `level`=15. The next step moves `phase` to 1 with `level` still 15. Two further steps give `phase`=2. Steps then decrement to 0, then `phase`=3, and after 2 steps `phase`=0. Full cycle = 36 steps.
3. **PWM:** force `level`=5 and check that `LED` is high exactly 5 of every 16 cycles. Change `level` to 9 mid-period → the new duty is applied only from the next period start (`count[3:0]`=0).
4. **Enable:**
   - drop `en` for 200 cycles → `LED`=0 the next cycle; `level` and `phase` are unchanged across any `count[5]` edges in that window;
   - raise `en` → the ramp continues from the frozen `level`.
5. **Async reset mid-ramp:** assert `RST` between clock edges at `level`=7 → `LED`, `level` and `phase` read 0 before the next edge.
6. **Count jump and first-edge step:**
   - jump `count` from 10 to 40 → exactly one step;
   - jump from 40 to 50 → no step;
   - release `RST` while `count`=33 → one step on the first edge.
